// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 controller state encoding, widths and init constants
package sha1_pkg;
  localparam int SHA1_WORD_W      = 32;
  localparam int SHA1_DIGEST_W    = 160;
  localparam int SHA1_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hefcdab89;
  localparam logic [31:0] SHA1_H2 = 32'h98badcfe;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hc3d2e1f0;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/sha1_ctrl_if.sv
// sha1_ctrl_if: requester-side bus of the SHA-1 controller
interface sha1_ctrl_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    init;
  logic [N_REQ*32-1:0] word;
  logic [N_REQ-1:0]    word_valid;
  logic [N_REQ-1:0]    word_ready;
  logic [N_REQ-1:0]    gnt;
  logic [159:0]        digest;
  logic [N_REQ-1:0]    digest_valid;
  logic                err;
  modport master (
    output req, init, word, word_valid,
    input  word_ready, gnt, digest, digest_valid, err
  );
  modport slave (
    input  req, init, word, word_valid,
    output word_ready, gnt, digest, digest_valid, err
  );
endinterface

// File: rtl/sha1_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // scan offsets from far to near so the nearest request after ptr wins
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      gnt = |(req & (N'(1) << ((int'(ptr) + i) % N))) ? N'(1) << ((int'(ptr) + i) % N) : gnt;
  end
endmodule

// File: rtl/sha1_ctrl.sv
// sha1_ctrl: round-robin sequencer sharing one SHA-1 core between requesters
module sha1_ctrl
  import sha1_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WORDS   = SHA1_BLOCK_WORDS,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha1_ctrl_if.slave               bus,
  output logic                     busy_o,
  output logic [SHA1_WORD_W-1:0]   core_word_o,
  output logic                     core_word_we_o,
  output logic                     core_init_o,
  output logic                     core_start_o,
  input  logic                     core_done_i,
  input  logic [SHA1_DIGEST_W-1:0] core_digest_i
);
  localparam int PW  = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int WCW = $clog2(WORDS) + 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t                   state_q, state_d;
  logic [N_REQ-1:0]         gnt_q, gnt_d, arb_gnt;
  logic [PW-1:0]            gidx_q, gidx_d, rr_q, rr_d, arb_idx;
  logic                     init_q, init_d, err_q, err_d, we_q, we_d;
  logic [WCW-1:0]           wcnt_q, wcnt_d;
  logic [TCW-1:0]           tcnt_q, tcnt_d;
  logic [SHA1_WORD_W-1:0]   word_q, word_d;
  logic [SHA1_DIGEST_W-1:0] digest_q, digest_d;
  logic                     load_full, xfer, tmo;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (.req(bus.req), .ptr(rr_q), .gnt(arb_gnt));

  // the counter saturates at WORDS so ready drops for one cycle before START
  assign load_full = wcnt_q == WCW'(WORDS);
  assign xfer      = state_q == ST_LOAD && !load_full && |(gnt_q & bus.word_valid);
  assign tmo       = tcnt_q == TCW'(TIMEOUT - 1);

  // encode the arbiter's one-hot pick for word muxing and pointer advance
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      arb_idx = |(arb_gnt & (N_REQ'(1) << i)) ? PW'(i) : arb_idx;
  end

  // all controller state; async reset aborts any block in flight silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      init_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      word_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      init_q   <= init_d;
      err_q    <= err_d;
      we_q     <= we_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      word_q   <= word_d;
      digest_q <= digest_d;
    end
  end

  // block sequencing: IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = |bus.req ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = load_full ? ST_START : ST_LOAD;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  state_d = core_done_i || tmo ? ST_DONE : ST_WAIT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // grant capture, word streaming, timeout counting and digest capture
  always_comb begin
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    init_d   = init_q;
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    word_d   = word_q;
    digest_d = digest_q;
    we_d     = xfer;
    if (state_q == ST_IDLE && |bus.req) begin
      gnt_d  = arb_gnt;
      gidx_d = arb_idx;
      init_d = |(arb_gnt & bus.init);
      wcnt_d = '0;
      err_d  = 1'b0;
    end
    if (xfer) begin
      word_d = bus.word[{gidx_q, 5'd0} +: SHA1_WORD_W];
      wcnt_d = wcnt_q + 1'b1;
    end
    if (state_q == ST_START) tcnt_d = '0;
    if (state_q == ST_WAIT) begin
      if (core_done_i) digest_d = core_digest_i;
      else if (tmo) err_d = 1'b1;
      else tcnt_d = tcnt_q + 1'b1;
    end
    if (state_q == ST_DONE) begin
      gnt_d  = '0;
      rr_d   = gidx_q == PW'(N_REQ - 1) ? '0 : gidx_q + 1'b1;
      wcnt_d = '0;
      tcnt_d = '0;
      err_d  = 1'b0;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    bus.word_ready     = state_q == ST_LOAD && !load_full ? gnt_q : '0;
    bus.gnt            = gnt_q;
    bus.digest         = digest_q;
    bus.digest_valid   = state_q == ST_DONE && !err_q ? gnt_q : '0;
    bus.err            = state_q == ST_DONE && err_q;
    busy_o             = state_q != ST_IDLE;
    core_word_o        = word_q;
    core_word_we_o     = we_q;
    core_start_o       = state_q == ST_START;
    core_init_o        = state_q == ST_START && init_q;
  end
endmodule

// File: tb/tb_sha1_ctrl.sv
// tb_sha1_ctrl: directed checks of the SHA-1 sequencer with a behavioural core
`timescale 1ns/1ps
module tb_sha1_ctrl;
  import sha1_pkg::*;
  localparam int N = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, core_we, core_init, core_start, core_done;
  logic [31:0] core_word;
  logic [159:0] core_digest;
  int cyc = 0;
  int checks = 0, failures = 0;

  sha1_ctrl_if #(.N_REQ(N)) bus ();

  sha1_ctrl #(.N_REQ(N), .WORDS(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy),
    .core_word_o(core_word), .core_word_we_o(core_we), .core_init_o(core_init),
    .core_start_o(core_start), .core_done_i(core_done), .core_digest_i(core_digest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [159:0] got, logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(logic [31:0] b, int i);
    return b + 32'h04040404 * 32'(i);
  endfunction

  function automatic logic [159:0] exp_dg(logic [31:0] b, bit init);
    logic [31:0] a, s;
    a = '0;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      a = {a[30:0], a[31]} ^ wd(b, i);
      s = s + wd(b, i);
    end
    return {a, s, 32'd16, init ? SHA1_H0 : 32'h0, 32'hA5A5A5A5};
  endfunction

  // core model and monitor state
  int lat = 80, spur_at = -1, done_at = 0, nw = 0;
  bit pend = 0;
  logic [31:0] acc = '0, sum = '0;
  logic [159:0] dg = '0;
  int t_gnt, we_first, we_last, we_n, t_start, t_dv, dv_n, t_err, err_n, overlap;
  logic st_init;
  logic [N-1:0] dv_val, prev_gnt = '0;
  logic [N-1:0] gseq[$];

  // requester model
  logic [31:0] base[N];
  int widx[N];
  bit gap[N];

  initial begin
    core_done = 1'b0;
    core_digest = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; acc = '0; sum = '0; nw = 0;
        core_done = 1'b0;
        core_digest = '0;
      end else begin
        if (core_we) begin
          acc = {acc[30:0], acc[31]} ^ core_word;
          sum = sum + core_word;
          nw++;
          if (we_n == 0) we_first = cyc;
          we_last = cyc;
          we_n++;
        end
        if (core_start) begin
          t_start = cyc;
          st_init = core_init;
          pend = lat > 0;
          done_at = cyc + lat;
          dg = {acc, sum, 32'(nw), core_init ? SHA1_H0 : 32'h0, 32'hA5A5A5A5};
          acc = '0; sum = '0; nw = 0;
        end
        core_done = (pend && cyc == done_at) || cyc == spur_at;
        core_digest = !core_done ? '0 : cyc == spur_at ? {5{32'hDEADBEEF}} : dg;
        if (pend && cyc == done_at) pend = 0;
      end
      if (bus.gnt != 0 && prev_gnt == 0) begin
        if (t_gnt < 0) t_gnt = cyc;
        gseq.push_back(bus.gnt);
      end
      prev_gnt = bus.gnt;
      if ($countones(bus.gnt) > 1) overlap++;
      if (bus.digest_valid != 0) begin dv_n++; t_dv = cyc; dv_val = bus.digest_valid; end
      if (bus.err) begin err_n++; t_err = cyc; end
    end
  end

  initial begin
    bus.req = '0; bus.init = '0; bus.word_valid = '0; bus.word = '0;
    for (int k = 0; k < N; k++) begin base[k] = '0; widx[k] = 16; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (bus.gnt[k]) bus.req[k] = 1'b0;
        bus.word_valid[k] = widx[k] < 16 && !(gap[k] && cyc[0]);
        bus.word[k*32 +: 32] = wd(base[k], widx[k]);
        if (bus.word_valid[k] && bus.word_ready[k] && rst_n) widx[k]++;
      end
    end
  end

  task automatic clr_mon();
    t_gnt = -1; we_first = -1; we_last = -1; we_n = 0; t_start = -1;
    t_dv = -1; dv_n = 0; t_err = -1; err_n = 0; overlap = 0; dv_val = '0;
    gseq.delete();
  endtask

  task automatic req(int k, logic [31:0] b, bit init);
    base[k] = b;
    widx[k] = 0;
    bus.init[k] = init;
    bus.req[k] = 1'b1;
  endtask

  task automatic wait_end(string tag, int n, int maxc);
    for (int i = 0; i < maxc && dv_n + err_n < n; i++) begin
      @(negedge clk); #1;
    end
    chk(tag, 160'(dv_n + err_n >= n), 160'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [159:0] last_exp;
    clr_mon();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_digest", bus.digest, 0);
    chk("rst_start", core_start, 0);
    chk("rst_we", core_we, 0);
    chk("rst_ready", bus.word_ready, 0);
    rst_n = 1'b1;

    // single requester, back-to-back words, done 80 cycles after start
    @(negedge clk); #1;
    clr_mon(); c0 = cyc;
    req(0, 32'h31323334, 1);
    wait_end("t1_wait", 1, 400);
    chk("t1_gnt_cyc", t_gnt - c0, 1);
    chk("t1_we_first", we_first - c0, 2);
    chk("t1_we_last", we_last - c0, 17);
    chk("t1_we_n", we_n, 16);
    chk("t1_start_cyc", t_start - c0, 18);
    chk("t1_init", st_init, 1);
    chk("t1_dv_cyc", t_dv - c0, 99);
    chk("t1_dv_val", dv_val, 2'b01);
    chk("t1_digest", bus.digest, exp_dg(32'h31323334, 1));
    chk("t1_err_n", err_n, 0);
    chk("t1_idle", busy, 0);

    // contention from reset, two rounds
    do_reset();
    chk("t2_rst_digest", bus.digest, 0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      clr_mon();
      req(0, 32'h41424344, 1);
      req(1, 32'h61626364, 1);
      wait_end("t2_wait", 2, 600);
      chk("t2_grants", gseq.size(), 2);
      chk("t2_first", gseq.size() > 0 ? gseq[0] : 2'b00, 2'b01);
      chk("t2_second", gseq.size() > 1 ? gseq[1] : 2'b00, 2'b10);
      chk("t2_overlap", overlap, 0);
      chk("t2_dv_last", dv_val, 2'b10);
      chk("t2_digest", bus.digest, exp_dg(32'h61626364, 1));
    end

    // valid gaps on every other cycle
    gap[0] = 1;
    @(negedge clk); #1;
    clr_mon();
    req(0, 32'h11223344, 1);
    wait_end("t3_wait", 1, 600);
    gap[0] = 0;
    last_exp = exp_dg(32'h11223344, 1);
    chk("t3_we_n", we_n, 16);
    chk("t3_start_after", t_start - we_last, 1);
    chk("t3_digest", bus.digest, last_exp);

    // timeout: core never finishes
    lat = 0;
    @(negedge clk); #1;
    clr_mon();
    req(1, 32'h71727374, 1);
    wait_end("t4_wait", 1, 600);
    lat = 80;
    chk("t4_err_n", err_n, 1);
    chk("t4_err_cyc", t_err - t_start, 256);
    chk("t4_dv_n", dv_n, 0);
    chk("t4_digest", bus.digest, last_exp);
    chk("t4_idle", busy, 0);

    // chaining with a spurious done during LOAD
    @(negedge clk); #1;
    clr_mon(); c0 = cyc;
    spur_at = c0 + 5;
    req(0, 32'h0a0b0c0d, 1);
    wait_end("t5a_wait", 1, 400);
    spur_at = -1;
    chk("t5a_gnt_cyc", t_gnt - c0, 1);
    chk("t5a_init", st_init, 1);
    chk("t5a_dv_n", dv_n, 1);
    chk("t5a_dv_cyc", t_dv - c0, 99);
    chk("t5a_digest", bus.digest, exp_dg(32'h0a0b0c0d, 1));
    @(negedge clk); #1;
    clr_mon();
    req(0, 32'h1a1b1c1d, 0);
    wait_end("t5b_wait", 1, 400);
    chk("t5b_init", st_init, 0);
    chk("t5b_digest", bus.digest, exp_dg(32'h1a1b1c1d, 0));

    // reset while loading, then restart from word 0
    @(negedge clk); #1;
    clr_mon();
    req(0, 32'h51525354, 1);
    for (int i = 0; i < 100 && we_n < 7; i++) begin
      @(negedge clk); #1;
    end
    chk("t6_reach7", we_n, 7);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", bus.gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", bus.word_ready, 0);
    chk("t6_word", core_word, 0);
    chk("t6_we", core_we, 0);
    chk("t6_digest", bus.digest, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t6_no_pulse", dv_n + err_n, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    clr_mon(); c0 = cyc;
    req(0, 32'h51525354, 1);
    wait_end("t6_wait", 1, 400);
    chk("t6_gnt_cyc", t_gnt - c0, 1);
    chk("t6_we_n", we_n, 16);
    chk("t6_dv_val", dv_val, 2'b01);
    chk("t6_re_digest", bus.digest, exp_dg(32'h51525354, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
